// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared event and state types for the keyboard event pacer
package kbd_pkg;

   typedef struct packed {
      logic       press;
      logic       ext;
      logic [7:0] code;
   } kbd_evt_t;

   typedef enum logic [1:0] {KP_PRIME, KP_IDLE, KP_HOLD} kbd_pacer_st_t;

   localparam int KBD_EVT_W = $bits(kbd_evt_t);

endpackage

// File: rtl/kbd_evt_fifo.sv
// rtl/kbd_evt_fifo.sv - synchronous FIFO of key events with simultaneous push/pop
module kbd_evt_fifo
   import kbd_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk_sys,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [KBD_EVT_W-1:0]     push_evt,
   input  logic                     pop,
   output logic [KBD_EVT_W-1:0]     head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   kbd_evt_t      mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   level_q;
   logic          do_push;
   logic          do_pop;

   assign empty   = (level_q == '0);
   assign full    = (level_q == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a push on full is still taken.
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];
   assign level   = level_q;

   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr] <= push_evt;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push & ~do_pop)      level_q <= level_q + 1'b1;
         else if (do_pop & ~do_push) level_q <= level_q - 1'b1;
      end
   end

endmodule

// File: rtl/kbd_event_pacer.sv
// rtl/kbd_event_pacer.sv - re-emits PS/2 key events spaced for the matrix scan, with injector port
module kbd_event_pacer
   import kbd_pkg::*;
#(
   parameter int  FIFO_DEPTH = 8,
   parameter int  HOLD_CYC   = 1_000_000,
   localparam int CW         = $clog2(HOLD_CYC + 1)
) (
   input  logic                          clk_sys,
   input  logic                          reset_n,
   input  logic [10:0]                   ps2_key_i,
   input  logic                          inj_valid,
   input  logic [9:0]                    inj_key,
   output logic                          inj_ready,
   input  logic                          ovf_clr,
   output logic [10:0]                   ps2_key_o,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYC - 1);

   kbd_pacer_st_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [10:0]   key_q, key_d;
   logic          old_t;
   logic          live_evt;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [9:0]    fifo_head;

   // PRIME swallows the first toggle comparison so a level held through reset is not an event.
   assign live_evt  = (old_t != ps2_key_i[10]) && (state_q != KP_PRIME);
   assign busy      = (state_q == KP_HOLD) || !fifo_empty;
   assign ps2_key_o = key_q;

   kbd_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .push     (live_evt),
      .push_evt (ps2_key_i[9:0]),
      .pop      (fifo_pop),
      .head     (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (fifo_level)
   );

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         old_t    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         old_t <= ps2_key_i[10];
         if (live_evt && fifo_full && !fifo_pop) overflow <= 1'b1;
         else if (ovf_clr)                       overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= KP_PRIME;
         cnt_q   <= '0;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      key_d     = key_q;
      fifo_pop  = 1'b0;
      inj_ready = 1'b0;
      case (state_q)
         KP_PRIME: state_d = KP_IDLE;
         KP_IDLE: begin
            inj_ready = fifo_empty;
            // Live traffic always wins; the injector only gets an idle, drained pacer.
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               key_d    = {~key_q[10], fifo_head};
               cnt_d    = HOLD_LOAD;
               state_d  = KP_HOLD;
            end else if (inj_valid) begin
               key_d    = {~key_q[10], inj_key};
               cnt_d    = HOLD_LOAD;
               state_d  = KP_HOLD;
            end
         end
         KP_HOLD: begin
            if (cnt_q == '0) state_d = KP_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = KP_IDLE;
      endcase
   end

endmodule

// File: tb/tb_kbd_event_pacer.sv
// tb/tb_kbd_event_pacer.sv - self-checking bench for kbd_event_pacer
module tb_kbd_event_pacer;

   typedef struct {
      logic [9:0]  key;
      logic [10:0] exp_o;
   } vec_t;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic [10:0] ps2_key_i;
   logic        inj_valid;
   logic [9:0]  inj_key;
   logic        ovf_clr;
   logic        inj_ready, busy, overflow;
   logic [10:0] ps2_key_o;
   logic [3:0]  fifo_level;
   logic        inj_ready_h, busy_h, overflow_h;
   logic [10:0] ps2_key_o_h;
   logic [3:0]  fifo_level_h;

   int checks = 0;
   int errors = 0;

   logic [9:0] exp_q[$];
   logic [9:0] exp_h[$];
   bit   mon_en = 0, mon_h_en = 0, gap_exact = 0, gap_ref = 0;
   int   cyc = 0, last_emit = 0, n_emit = 0, n_emit_h = 0;
   logic prev_t = 1'b0, prev_t_h = 1'b0;

   vec_t tbl[6];

   always #5 clk_sys = ~clk_sys;

   kbd_event_pacer #(.FIFO_DEPTH(8), .HOLD_CYC(4)) u_dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key_i(ps2_key_i),
      .inj_valid(inj_valid), .inj_key(inj_key), .inj_ready(inj_ready),
      .ovf_clr(ovf_clr), .ps2_key_o(ps2_key_o), .busy(busy),
      .overflow(overflow), .fifo_level(fifo_level)
   );

   kbd_event_pacer #(.FIFO_DEPTH(8), .HOLD_CYC(100)) u_dut_h (
      .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key_i(ps2_key_i),
      .inj_valid(inj_valid), .inj_key(inj_key), .inj_ready(inj_ready_h),
      .ovf_clr(ovf_clr), .ps2_key_o(ps2_key_o_h), .busy(busy_h),
      .overflow(overflow_h), .fifo_level(fifo_level_h)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #2;
   endtask

   task automatic samp();
      @(negedge clk_sys);
      #1;
   endtask

   task automatic live(input logic [9:0] k);
      ps2_key_i = {~ps2_key_i[10], k};
   endtask

   // Scoreboard: every toggle of an output is an emission, compared against the queue head.
   always @(negedge clk_sys) begin
      cyc++;
      if (reset_n && mon_en && ps2_key_o[10] !== prev_t) begin
         n_emit++;
         if (exp_q.size() == 0) fail_now("unexpected_emit");
         else check("emit_key", {22'd0, ps2_key_o[9:0]}, {22'd0, exp_q.pop_front()});
         if (gap_ref) begin
            if (gap_exact) check("emit_gap", cyc - last_emit, 5);
            else if (cyc - last_emit < 5) fail_now("emit_gap_min");
         end
         gap_ref   = 1;
         last_emit = cyc;
      end
      prev_t = ps2_key_o[10];
      if (reset_n && mon_h_en && ps2_key_o_h[10] !== prev_t_h) begin
         n_emit_h++;
         if (exp_h.size() == 0) fail_now("unexpected_emit_h");
         else check("emit_key_h", {22'd0, ps2_key_o_h[9:0]}, {22'd0, exp_h.pop_front()});
      end
      prev_t_h = ps2_key_o_h[10];
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bc, base, k;
      tbl[0] = '{10'h21C, 11'h61C};
      tbl[1] = '{10'h01C, 11'h01C};
      tbl[2] = '{10'h375, 11'h775};
      tbl[3] = '{10'h175, 11'h175};
      tbl[4] = '{10'h2F0, 11'h6F0};
      tbl[5] = '{10'h0F0, 11'h0F0};

      reset_n = 1'b0; ps2_key_i = 11'h400; inj_valid = 1'b0; inj_key = '0; ovf_clr = 1'b0;

      // 1: toggle bit held high through reset release must not produce an event
      tick(3);
      reset_n = 1'b1;
      tick(3);
      samp();
      check("rst_o", ps2_key_o, 0);
      check("rst_busy", busy, 0);
      check("rst_level", fifo_level, 0);
      check("rst_inj_ready", inj_ready, 1);
      check("rst_ovf", overflow, 0);
      mon_en = 1;
      tick(1);

      // 2: single live events from the table
      for (int i = 0; i < 6; i++) begin
         live(tbl[i].key);
         exp_q.push_back(tbl[i].key);
         tick(1);
         samp();
         check("cap_level", fifo_level, 1);
         check("cap_inj_ready", inj_ready, 0);
         check("cap_o_held", ps2_key_o, (i == 0) ? 11'h000 : tbl[i-1].exp_o);
         tick(1);
         samp();
         check("emit_o", ps2_key_o, tbl[i].exp_o);
         check("emit_inj_ready", inj_ready, 0);
         bc = 2;
         for (int j = 0; j < 20; j++) begin
            tick(1);
            samp();
            if (!busy) break;
            bc++;
         end
         check("busy_cycles", bc, 5);
         check("idle_inj_ready", inj_ready, 1);
         tick(1);
      end

      // 3: back-to-back live events come out in order exactly 5 clocks apart
      gap_ref = 0; gap_exact = 1; base = n_emit;
      live(10'h21C); exp_q.push_back(10'h21C); tick(1);
      live(10'h21B); exp_q.push_back(10'h21B); tick(1);
      live(10'h223); exp_q.push_back(10'h223); tick(1);
      k = 0;
      while (k < 40) begin samp(); if (!busy) break; tick(1); k++; end
      if (k >= 40) fail_now("burst_drain_timeout");
      check("burst_count", n_emit - base, 3);
      check("burst_queue_empty", exp_q.size(), 0);
      tick(1);

      // 5: injector blocked while live traffic pending, then same-cycle live event queued behind it
      gap_ref = 0; base = n_emit;
      live(10'h25A); exp_q.push_back(10'h25A); tick(1);
      live(10'h15A); exp_q.push_back(10'h15A);
      inj_valid = 1'b1; inj_key = 10'h215; exp_q.push_back(10'h215);
      tick(1);
      k = 0;
      while (k < 40) begin
         samp();
         check("inj_ready_model", inj_ready, (fifo_level == 0) && !busy);
         if (inj_ready) break;
         tick(1); k++;
      end
      if (k >= 40) fail_now("inj_ready_timeout");
      live(10'h0A5); exp_q.push_back(10'h0A5);
      tick(1);
      inj_valid = 1'b0;
      samp();
      check("inj_emit_o", ps2_key_o[9:0], 10'h215);
      check("inj_live_queued", fifo_level, 1);
      check("inj_ready_after", inj_ready, 0);
      k = 0;
      while (k < 40) begin samp(); if (!busy) break; tick(1); k++; end
      if (k >= 40) fail_now("inj_drain_timeout");
      check("inj_count", n_emit - base, 4);
      check("inj_last_o", ps2_key_o[9:0], 10'h0A5);
      gap_exact = 0;
      tick(1);

      // 4: HOLD_CYC=100 instance, overflow on the 10th of 10 sparse events
      mon_en = 0; exp_q.delete();
      reset_n = 1'b0; tick(2); reset_n = 1'b1; tick(3);
      mon_h_en = 1; base = n_emit_h;
      for (int i = 0; i < 10; i++) begin
         live({2'b10, 8'h10 + 8'(i)});
         if (i < 9) exp_h.push_back({2'b10, 8'h10 + 8'(i)});
         tick(2);
      end
      samp();
      check("ovf_set", overflow_h, 1);
      check("ovf_level", fifo_level_h, 8);
      check("ovf_busy", busy_h, 1);
      tick(1);
      ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
      samp();
      check("ovf_clr", overflow_h, 0);
      k = 0;
      while (k < 1500) begin samp(); if (!busy_h) break; tick(1); k++; end
      if (k >= 1500) fail_now("ovf_drain_timeout");
      check("ovf_emits", n_emit_h - base, 9);
      check("ovf_queue_empty", exp_h.size(), 0);
      mon_h_en = 0;
      tick(1);

      // 6: reset mid-HOLD discards queued events
      reset_n = 1'b0; tick(2); reset_n = 1'b1; tick(3);
      mon_en = 1; gap_ref = 0;
      live(10'h301); exp_q.push_back(10'h301); tick(1);
      live(10'h302); tick(1);
      live(10'h303); tick(1);
      live(10'h304); tick(1);
      samp();
      check("mid_level", fifo_level, 3);
      check("mid_o", ps2_key_o, 11'h701);
      tick(1);
      reset_n = 1'b0;
      #1;
      check("arst_o", ps2_key_o, 0);
      check("arst_level", fifo_level, 0);
      check("arst_busy", busy, 0);
      check("arst_inj_ready", inj_ready, 0);
      base = n_emit;
      tick(3);
      reset_n = 1'b1;
      tick(30);
      samp();
      check("post_rst_emits", n_emit - base, 0);
      check("post_rst_o", ps2_key_o, 0);
      check("post_rst_queue", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
